// File: rtl/alu_result_buffer.sv
// ALU result output stage: a 2-entry skid buffer with a registered i_in_ready,
// a sticky overflow flag and a wrapping count of delivered results.
module alu_result_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_y,
    input  logic             i_in_zero,
    input  logic             i_in_overflow,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_y,
    output logic             o_out_zero,
    output logic             o_out_overflow,
    input  logic             i_clr_sticky,
    output logic             o_sticky_ovf,
    output logic [CNT_W-1:0] o_result_count
);

    localparam int unsigned PW = WIDTH + 2;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [PW-1:0]     r_main;
    logic [PW-1:0]     r_skid;
    logic [PW-1:0]     w_main_d;
    logic [PW-1:0]     w_skid_d;
    logic [PW-1:0]     w_in_payload;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_count;
    logic              w_accept;
    logic              w_deliver;

    // Both handshake flags come straight from the state register, so neither
    // side sees a combinational path from the other.
    assign o_in_ready   = (r_state != StTwo);
    assign o_out_valid  = (r_state != StEmpty);
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_deliver    = o_out_valid & i_out_ready;
    assign w_in_payload = {i_in_y, i_in_zero, i_in_overflow};

    // Head fields only ever come from the main register.
    assign o_out_y        = r_main[PW-1:2];
    assign o_out_zero     = r_main[1];
    assign o_out_overflow = r_main[0];
    assign o_sticky_ovf   = r_sticky;
    assign o_result_count = r_count;

    // Next-state and entry routing for the skid buffer.
    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = r_skid;
        unique case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_state_d = StOne;
                    w_main_d  = w_in_payload;
                end
            end
            StOne: begin
                if (w_accept && w_deliver) begin
                    w_main_d = w_in_payload;
                end else if (w_accept) begin
                    w_state_d = StTwo;
                    w_skid_d  = w_in_payload;
                end else if (w_deliver) begin
                    w_state_d = StEmpty;
                end
            end
            StTwo: begin
                // i_in_ready is low here, so only the head can move.
                if (w_deliver) begin
                    w_state_d = StOne;
                    w_main_d  = r_skid;
                end
            end
            default: w_state_d = StEmpty;
        endcase
    end

    // State, payload registers, sticky flag and delivery counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StEmpty;
            r_main   <= '0;
            r_skid   <= '0;
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_main   <= w_main_d;
            r_skid   <= w_skid_d;
            // Set wins over a same-cycle clear.
            r_sticky <= (r_sticky & ~i_clr_sticky) | (w_accept & i_in_overflow);
            r_count  <= r_count + CNT_W'(w_deliver);
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_y;
    logic        in_zero;
    logic        in_overflow;
    logic        out_ready;
    logic        clr_sticky;

    logic        in_ready, out_valid, out_zero, out_overflow, sticky_ovf;
    logic [31:0] out_y;
    logic [15:0] result_count;

    logic        in_ready4, out_valid4, out_zero4, out_overflow4, sticky_ovf4;
    logic [31:0] out_y4;
    logic [3:0]  result_count4;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of {y, zero, ovf}, last head, sticky, delivery count.
    logic [33:0] q[$];
    logic [33:0] hd;
    logic        m_sticky;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    alu_result_buffer #(.WIDTH(32), .CNT_W(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_y         (in_y),
        .i_in_zero      (in_zero),
        .i_in_overflow  (in_overflow),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_y        (out_y),
        .o_out_zero     (out_zero),
        .o_out_overflow (out_overflow),
        .i_clr_sticky   (clr_sticky),
        .o_sticky_ovf   (sticky_ovf),
        .o_result_count (result_count)
    );

    alu_result_buffer #(.WIDTH(32), .CNT_W(4)) dut4 (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready4),
        .i_in_y         (in_y),
        .i_in_zero      (in_zero),
        .i_in_overflow  (in_overflow),
        .o_out_valid    (out_valid4),
        .i_out_ready    (out_ready),
        .o_out_y        (out_y4),
        .o_out_zero     (out_zero4),
        .o_out_overflow (out_overflow4),
        .i_clr_sticky   (clr_sticky),
        .o_sticky_ovf   (sticky_ovf4),
        .o_result_count (result_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check all outputs.
    task automatic cyc(input logic rst, input logic v, input logic [31:0] y, input logic z,
                       input logic o, input logic rdy, input logic clr);
        logic acc, del;
        reset = rst; in_valid = v; in_y = y; in_zero = z; in_overflow = o;
        out_ready = rdy; clr_sticky = clr;
        @(posedge clk);
        if (rst) begin
            q.delete();
            hd = '0;
            m_sticky = 1'b0;
            m_cnt = 0;
        end else begin
            acc = v && (q.size() < 2);
            del = (q.size() > 0) && rdy;
            if (del) void'(q.pop_front());
            if (acc) q.push_back({y, z, o});
            if (del) m_cnt++;
            m_sticky = (m_sticky && !clr) || (acc && o);
            if (q.size() > 0) hd = q[0];
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_y", 64'(out_y), 64'(hd[33:2]));
        chk("out_zero", 64'(out_zero), 64'(hd[1]));
        chk("out_overflow", 64'(out_overflow), 64'(hd[0]));
        chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
        chk("result_count", 64'(result_count), 64'(m_cnt % 65536));
        chk("result_count_w4", 64'(result_count4), 64'(m_cnt % 16));
    endtask

    initial begin
        hd = '0;
        m_sticky = 1'b0;
        m_cnt = 0;
        #1;

        // Reset state
        cyc(1, 1, 32'hdead_beef, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single result, one-cycle latency, then delivered
        cyc(0, 1, 32'h0000_0005, 0, 0, 1, 0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_y", 64'(out_y), 64'd5);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("t1_count", 64'(result_count), 64'd1);

        // Fill both entries with out_ready low; C blocked; then drain in order
        cyc(0, 1, 32'h1, 0, 0, 0, 0);
        cyc(0, 1, 32'h2, 1, 0, 0, 0);
        chk("t2_full", 64'(in_ready), 64'd0);
        cyc(0, 1, 32'h3, 0, 0, 0, 0);
        chk("t2_hold_a", 64'(out_y), 64'd1);
        cyc(0, 1, 32'h3, 0, 0, 1, 0);
        chk("t2_head_b", 64'(out_y), 64'd2);
        cyc(0, 1, 32'h3, 0, 0, 1, 0);
        chk("t2_head_c", 64'(out_y), 64'd3);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("t2_count", 64'(result_count), 64'd4);
        chk("t2_empty", 64'(out_valid), 64'd0);
        chk("t2_hold_last", 64'(out_y), 64'd3);

        // Stream 100 results at full rate
        for (int i = 0; i < 100; i++) begin
            cyc(0, 1, 32'h1000 + 32'(i), 0, 0, 1, 0);
            chk("t3_y", 64'(out_y), 64'(32'h1000 + 32'(i)));
        end
        cyc(0, 0, 0, 0, 0, 1, 0);

        // Sticky: set wins over simultaneous clear, clear alone drops it
        cyc(0, 1, 32'h7, 0, 1, 1, 1);
        chk("t4_set", 64'(sticky_ovf), 64'd1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("t4_clr", 64'(sticky_ovf), 64'd0);

        // 4-bit counter wraps after 17 deliveries
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, 1, 32'(i), 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("t5_wrap", 64'(result_count4), 64'd1);

        // Reset while two entries held
        cyc(0, 1, 32'ha, 0, 1, 0, 0);
        cyc(0, 1, 32'hb, 0, 0, 0, 0);
        chk("t6_full", 64'(in_ready), 64'd0);
        cyc(1, 1, 32'hc, 0, 1, 1, 0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_count", 64'(result_count), 64'd0);
        chk("t6_sticky", 64'(sticky_ovf), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom()), $urandom(), 1'($urandom()),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
